// File: rtl/aline_delay_sequencer_pkg.sv
// Shared definitions for the A-line delay sequencer: table geometry, counter
// widths, FSM state encoding and small helpers used by the RTL and the bench.
package aline_delay_sequencer_pkg;

    localparam int NUM_CHANNELS       = 8;
    localparam int COUNT_BITS         = 16;
    localparam int ALINE_BITS         = 6;
    localparam int PRI_BITS           = 24;
    localparam int CH_BITS            = 3;
    localparam int TX_TIMEOUT_DEFAULT = 65535;
    localparam int BUS_BITS           = NUM_CHANNELS * COUNT_BITS;

    // 8 read-issue cycles plus one to land the last word.
    localparam int FETCH_CYCLES = NUM_CHANNELS + 1;
    localparam int FETCH_BITS   = 4;

    // The PRI counter reads k-1 in the k-th cycle after ARM, and the next ARM
    // follows the PRI_WAIT exit by FETCH_CYCLES+1 cycles. Exiting once
    // cnt + PRI_LEAD >= cfg_pri lands the next ARM exactly cfg_pri cycles
    // after this one (or as soon as the transmit handshake allows).
    localparam int PRI_LEAD = FETCH_CYCLES + 2;

    typedef logic [ALINE_BITS:0] num_t;
    typedef logic [PRI_BITS:0]   pri_ext_t;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_FETCH,
        SEQ_ARM,
        SEQ_WAIT_TX,
        SEQ_PRI_WAIT
    } seq_state_t;

    // A-lines per frame: 0 behaves as 1, anything above the table depth clamps.
    function automatic num_t eff_num_alines(input num_t n);
        if (n == '0) return num_t'(1);
        if (n > num_t'(2 ** ALINE_BITS)) return num_t'(2 ** ALINE_BITS);
        return n;
    endfunction

    // LSB of channel ch inside the packed delay bus.
    function automatic int ch_lsb(input int ch);
        return ch * COUNT_BITS;
    endfunction

endpackage

// File: rtl/aline_delay_sequencer_if.sv
// Table-write and transmit-handshake signals of the A-line delay sequencer.
//   cfg_we/cfg_aline/cfg_ch/cfg_delay : delay table write port (host -> sequencer)
//   delay_bus                         : packed channel delays (sequencer -> tx FSM)
//   input_delay_data                  : 1-cycle load pulse (sequencer -> tx FSM)
//   aline_index                       : A-line being presented
//   transmit_complete                 : level from the tx FSM, rising edge = sent
// master = sequencer side, slave = host / transmit side.
interface aline_delay_sequencer_if;
    import aline_delay_sequencer_pkg::*;

    logic                  cfg_we;
    logic [ALINE_BITS-1:0] cfg_aline;
    logic [CH_BITS-1:0]    cfg_ch;
    logic [COUNT_BITS-1:0] cfg_delay;
    logic [BUS_BITS-1:0]   delay_bus;
    logic                  input_delay_data;
    logic [ALINE_BITS-1:0] aline_index;
    logic                  transmit_complete;

    modport master (
        input  cfg_we, cfg_aline, cfg_ch, cfg_delay, transmit_complete,
        output delay_bus, input_delay_data, aline_index
    );

    modport slave (
        output cfg_we, cfg_aline, cfg_ch, cfg_delay, transmit_complete,
        input  delay_bus, input_delay_data, aline_index
    );

endinterface

// File: rtl/aline_delay_sequencer_ram.sv
// Delay table storage: one write port, one synchronous read port (1-cycle
// latency). Contents are not reset.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address {aline, ch}
//   i_wdata : write data
//   i_raddr : read address {aline, ch}
//   o_rdata : read data, valid the cycle after i_raddr
module aline_delay_sequencer_ram #(
    parameter int DATA_BITS = 16,
    parameter int ADDR_BITS = 9
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [DATA_BITS-1:0] i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [DATA_BITS-1:0] o_rdata
);

    logic [DATA_BITS-1:0] r_mem [2**ADDR_BITS];
    logic [DATA_BITS-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/aline_delay_sequencer.sv
// A-line delay sequencer: plays a per-A-line, per-channel delay table out to
// the transmit FSM, one A-line per pulse repetition interval.
//   clk, rst          : clock, synchronous active-high reset
//   bus (master)      : table write port and transmit handshake
//   i_cfg_num_alines  : A-lines per frame (0 -> 1, clamps at table depth)
//   i_cfg_pri         : cycles from one ARM to the next
//   i_continuous      : wrap to A-line 0 after the last A-line
//   i_start / i_stop  : start request (IDLE only) / graceful stop
//   o_busy            : high outside IDLE
//   o_frame_done      : 1-cycle pulse at the last A-line's PRI exit
//   o_error_timeout   : sticky transmit timeout flag
//
// state        | meaning
// SEQ_IDLE     | waiting for start; table writable
// SEQ_FETCH    | reading 8 channel delays into the shadow register (9 cycles)
// SEQ_ARM      | shadow on delay_bus, input_delay_data pulse
// SEQ_WAIT_TX  | waiting for transmit_complete rising edge or timeout
// SEQ_PRI_WAIT | waiting for PRI, then next-A-line decision
module aline_delay_sequencer
    import aline_delay_sequencer_pkg::*;
#(
    parameter int TX_TIMEOUT = TX_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    aline_delay_sequencer_if.master bus,
    input  logic [ALINE_BITS:0]   i_cfg_num_alines,
    input  logic [PRI_BITS-1:0]   i_cfg_pri,
    input  logic                  i_continuous,
    input  logic                  i_start,
    input  logic                  i_stop,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_error_timeout
);

    localparam int TO_BITS = $clog2(TX_TIMEOUT + 1);

    seq_state_t            r_state, w_state_next;
    logic [FETCH_BITS-1:0] r_fetch_cnt;
    logic [BUS_BITS-1:0]   r_shadow, w_shadow_next, r_delay_bus;
    logic [PRI_BITS-1:0]   r_pri_cnt;
    logic [TO_BITS-1:0]    r_to_cnt;
    logic [ALINE_BITS-1:0] r_aline, w_aline_next;
    logic                  r_tc_prev, r_stop, r_error;
    logic [COUNT_BITS-1:0] w_rdata;
    logic [CH_BITS-1:0]    w_cap_ch;
    logic                  w_we, w_tx_edge, w_pri_done, w_last, w_stop_req;
    logic                  w_timeout, w_frame_done, w_fetch_last;

    assign w_we         = bus.cfg_we && (r_state == SEQ_IDLE);
    assign w_tx_edge    = bus.transmit_complete && !r_tc_prev;
    assign w_stop_req   = r_stop || i_stop;
    assign w_fetch_last = (r_fetch_cnt == FETCH_BITS'(FETCH_CYCLES - 1));
    assign w_pri_done   = (pri_ext_t'(r_pri_cnt) + pri_ext_t'(PRI_LEAD)) >= pri_ext_t'(i_cfg_pri);
    assign w_last       = (num_t'(r_aline) + num_t'(1)) >= eff_num_alines(i_cfg_num_alines);

    aline_delay_sequencer_ram #(
        .DATA_BITS (COUNT_BITS),
        .ADDR_BITS (ALINE_BITS + CH_BITS)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr ({bus.cfg_aline, bus.cfg_ch}),
        .i_wdata (bus.cfg_delay),
        .i_raddr ({r_aline, r_fetch_cnt[CH_BITS-1:0]}),
        .o_rdata (w_rdata)
    );

    // Read data arriving in fetch cycle n belongs to channel n-1.
    assign w_cap_ch = CH_BITS'(r_fetch_cnt - 1'b1);

    always_comb begin
        w_shadow_next = r_shadow;
        w_shadow_next[ch_lsb(int'(w_cap_ch)) +: COUNT_BITS] = w_rdata;
    end

    always_comb begin
        w_state_next = r_state;
        w_aline_next = r_aline;
        w_timeout    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                if (i_start) begin
                    w_state_next = SEQ_FETCH;
                    w_aline_next = '0;
                end
            end
            SEQ_FETCH: begin
                if (w_fetch_last) w_state_next = SEQ_ARM;
            end
            SEQ_ARM: begin
                w_state_next = SEQ_WAIT_TX;
            end
            SEQ_WAIT_TX: begin
                if (w_tx_edge) begin
                    w_state_next = SEQ_PRI_WAIT;
                end else if (r_to_cnt == '0) begin
                    w_state_next = SEQ_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            SEQ_PRI_WAIT: begin
                if (w_pri_done) begin
                    if (w_stop_req) begin
                        w_state_next = SEQ_IDLE;
                    end else if (!w_last) begin
                        w_state_next = SEQ_FETCH;
                        w_aline_next = r_aline + 1'b1;
                    end else begin
                        w_frame_done = 1'b1;
                        if (i_continuous) begin
                            w_state_next = SEQ_FETCH;
                            w_aline_next = '0;
                        end else begin
                            w_state_next = SEQ_IDLE;
                        end
                    end
                end
            end
            default: w_state_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SEQ_IDLE;
            r_fetch_cnt <= '0;
            r_shadow    <= '0;
            r_delay_bus <= '0;
            r_pri_cnt   <= '0;
            r_to_cnt    <= '0;
            r_aline     <= '0;
            r_tc_prev   <= 1'b0;
            r_stop      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_aline   <= w_aline_next;
            r_tc_prev <= bus.transmit_complete;

            if (r_state == SEQ_FETCH) r_fetch_cnt <= r_fetch_cnt + 1'b1;
            else                      r_fetch_cnt <= '0;

            if (r_state == SEQ_FETCH && r_fetch_cnt != '0) r_shadow <= w_shadow_next;
            // Output only moves here, so it stays put through the downstream load.
            if (r_state == SEQ_FETCH && w_fetch_last) r_delay_bus <= w_shadow_next;

            if (r_state == SEQ_ARM)  r_pri_cnt <= '0;
            else if (r_pri_cnt != '1) r_pri_cnt <= r_pri_cnt + 1'b1;

            if (r_state == SEQ_ARM) r_to_cnt <= TO_BITS'(TX_TIMEOUT - 1);
            else if (r_state == SEQ_WAIT_TX && r_to_cnt != '0) r_to_cnt <= r_to_cnt - 1'b1;

            if (w_state_next == SEQ_IDLE) r_stop <= 1'b0;
            else if (r_state != SEQ_IDLE && i_stop) r_stop <= 1'b1;

            if (r_state == SEQ_IDLE && i_start) r_error <= 1'b0;
            else if (w_timeout) r_error <= 1'b1;
        end
    end

    assign bus.delay_bus        = r_delay_bus;
    assign bus.input_delay_data = (r_state == SEQ_ARM);
    assign bus.aline_index      = r_aline;
    assign o_busy               = (r_state != SEQ_IDLE);
    assign o_frame_done         = w_frame_done;
    assign o_error_timeout      = r_error;

endmodule

// File: tb/tb_aline_delay_sequencer.sv
// Self-checking bench for aline_delay_sequencer. Expected pulse times, bus
// contents, frame_done and idle times come from a table model plus the
// timing rule: A-line period = max(pri, 11 + transmit latency), first pulse
// 10 cycles after start, decision max(lat+1, pri-10) cycles after a pulse.
module tb_aline_delay_sequencer;
    import aline_delay_sequencer_pkg::*;

    localparam int TXT = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aline_delay_sequencer_if bus_if();

    logic [ALINE_BITS:0] cfg_num;
    logic [PRI_BITS-1:0] cfg_pri;
    logic continuous, start, stop;
    logic busy, frame_done, error_timeout;

    aline_delay_sequencer #(.TX_TIMEOUT(TXT)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus_if),
        .i_cfg_num_alines (cfg_num),
        .i_cfg_pri        (cfg_pri),
        .i_continuous     (continuous),
        .i_start          (start),
        .i_stop           (stop),
        .o_busy           (busy),
        .o_frame_done     (frame_done),
        .o_error_timeout  (error_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tx_lat = 20;

    logic [COUNT_BITS-1:0] tbl [64][8];

    int                  p_cyc[$];
    logic [BUS_BITS-1:0] p_bus[$];
    int                  p_idx[$];
    int                  fd_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.input_delay_data) begin
                p_cyc.push_back(cyc);
                p_bus.push_back(bus_if.delay_bus);
                p_idx.push_back(int'(bus_if.aline_index));
            end
            if (frame_done) fd_cyc.push_back(cyc);
        end
    end

    // Transmit FSM stand-in: raises transmit_complete tx_lat cycles after a pulse.
    initial begin
        bus_if.transmit_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.input_delay_data && !rst && tx_lat > 0) begin
                repeat (tx_lat) @(negedge clk);
                bus_if.transmit_complete = 1'b1;
                repeat (3) @(negedge clk);
                bus_if.transmit_complete = 1'b0;
            end
        end
    end

    task automatic check_val(input string tag, input logic [BUS_BITS-1:0] got,
                             input logic [BUS_BITS-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [BUS_BITS-1:0] model_bus(input int a);
        logic [BUS_BITS-1:0] r;
        r = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) r[c*COUNT_BITS +: COUNT_BITS] = tbl[a][c];
        return r;
    endfunction

    task automatic clear_q();
        p_cyc.delete(); p_bus.delete(); p_idx.delete(); fd_cyc.delete();
    endtask

    task automatic write_cell(input int a, input int c, input logic [COUNT_BITS-1:0] v,
                              input bit apply);
        bus_if.cfg_we    = 1'b1;
        bus_if.cfg_aline = ALINE_BITS'(a);
        bus_if.cfg_ch    = CH_BITS'(c);
        bus_if.cfg_delay = v;
        @(negedge clk);
        bus_if.cfg_we = 1'b0;
        if (apply) tbl[a][c] = v;
    endtask

    task automatic kick(output int s);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output int t);
        t = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) begin
                t = cyc;
                break;
            end
        end
        check_val("idle_reached", busy, 0);
    endtask

    task automatic check_zero_outputs();
        check_val("rst_busy", busy, 0);
        check_val("rst_pulse", bus_if.input_delay_data, 0);
        check_val("rst_bus", bus_if.delay_bus, 0);
        check_val("rst_index", bus_if.aline_index, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_error", error_timeout, 0);
    endtask

    task automatic verify_frame(input int s, input int num, input int pri, input int lat,
                                input int t_idle);
        int n, per, tail, last;
        n    = (num == 0) ? 1 : ((num > 64) ? 64 : num);
        per  = imax(pri, 11 + lat);
        tail = imax(lat + 1, pri - 10);
        last = s + 10 + (n - 1) * per;
        check_val("n_pulses", p_cyc.size(), n);
        for (int k = 0; k < n && k < p_cyc.size(); k++) begin
            check_val("t_pulse", p_cyc[k], s + 10 + k * per);
            check_val("delay_bus", p_bus[k], model_bus(k));
            check_val("aline_index", p_idx[k], k);
        end
        check_val("n_frame_done", fd_cyc.size(), 1);
        if (fd_cyc.size() > 0) check_val("t_frame_done", fd_cyc[0], last + tail);
        check_val("t_idle", t_idle, last + tail + 1);
        check_val("error_clear", error_timeout, 0);
    endtask

    task automatic run_frame(input int num, input int pri, input int lat,
                             input bit wr_with_start, input bit stop_with_start);
        int s, t;
        logic [COUNT_BITS-1:0] v;
        cfg_num    = (ALINE_BITS+1)'(num);
        cfg_pri    = PRI_BITS'(pri);
        tx_lat     = lat;
        continuous = 1'b0;
        clear_q();
        if (wr_with_start) begin
            v = COUNT_BITS'($urandom);
            bus_if.cfg_we    = 1'b1;
            bus_if.cfg_aline = 1;
            bus_if.cfg_ch    = 3;
            bus_if.cfg_delay = v;
            tbl[1][3] = v;
        end
        stop = stop_with_start;
        kick(s);
        bus_if.cfg_we = 1'b0;
        stop = 1'b0;
        wait_idle(30000, t);
        verify_frame(s, num, pri, lat, t);
    endtask

    task automatic cont_stop(input int n_stop);
        int s, t, last;
        cfg_num = 2; cfg_pri = 40; tx_lat = 10; continuous = 1'b1;
        clear_q();
        kick(s);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (p_cyc.size() >= n_stop) break;
        end
        repeat (2) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle(3000, t);
        continuous = 1'b0;
        last = s + 10 + (n_stop - 1) * 40;
        check_val("stop_n_pulses", p_cyc.size(), n_stop);
        for (int k = 0; k < n_stop && k < p_cyc.size(); k++) begin
            check_val("stop_t_pulse", p_cyc[k], s + 10 + k * 40);
            check_val("stop_index", p_idx[k], k % 2);
            check_val("stop_bus", p_bus[k], model_bus(k % 2));
        end
        check_val("stop_n_frame_done", fd_cyc.size(), (n_stop - 1) / 2);
        check_val("stop_t_idle", t, last + 30 + 1);
    endtask

    task automatic rst_mid(input int wait_cycles);
        int s;
        cfg_num = 3; cfg_pri = 200; tx_lat = 5; continuous = 1'b0;
        clear_q();
        kick(s);
        repeat (wait_cycles) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run_frame(2, 30, 5, 1'b0, 1'b0);
    endtask

    initial begin
        int s, t, num, pri, lat;
        logic [COUNT_BITS-1:0] old_v;
        bus_if.cfg_we = 1'b0; bus_if.cfg_aline = '0; bus_if.cfg_ch = '0; bus_if.cfg_delay = '0;
        cfg_num = 1; cfg_pri = 0; continuous = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs();
        rst = 1'b0;
        @(negedge clk);

        for (int a = 0; a < 64; a++)
            for (int c = 0; c < NUM_CHANNELS; c++)
                write_cell(a, c, (a < 4) ? COUNT_BITS'(10 * a + c) : COUNT_BITS'($urandom), 1'b1);

        run_frame(4, 100, 20, 1'b0, 1'b0);
        run_frame(3, 1, 5, 1'b0, 1'b0);

        for (int it = 0; it < 4; it++) begin
            num = $urandom_range(1, 8);
            pri = $urandom_range(0, 80);
            lat = $urandom_range(2, 30);
            for (int w = 0; w < 4; w++)
                write_cell($urandom_range(0, 7), $urandom_range(0, 7), COUNT_BITS'($urandom), 1'b1);
            run_frame(num, pri, lat, 1'b0, 1'b0);
        end

        run_frame(0, 0, 3, 1'b0, 1'b0);
        run_frame(100, 0, 2, 1'b0, 1'b0);
        run_frame(2, 20, 4, 1'b1, 1'b0);

        // Transmit never completes.
        cfg_num = 2; cfg_pri = 0; tx_lat = 0;
        clear_q();
        kick(s);
        wait_idle(TXT + 100, t);
        check_val("to_n_pulses", p_cyc.size(), 1);
        if (p_cyc.size() > 0) check_val("to_t_pulse", p_cyc[0], s + 10);
        check_val("to_t_idle", t, s + 10 + TXT + 1);
        check_val("to_error_set", error_timeout, 1);
        check_val("to_n_frame_done", fd_cyc.size(), 0);
        repeat (2) @(negedge clk);
        check_val("to_error_sticky", error_timeout, 1);
        cfg_num = 1; tx_lat = 5;
        clear_q();
        kick(s);
        check_val("to_error_cleared", error_timeout, 0);
        wait_idle(1000, t);
        verify_frame(s, 1, 0, 5, t);

        cont_stop(2);
        cont_stop(3);

        // Writes and a start while busy must be ignored.
        cfg_num = 2; cfg_pri = 60; tx_lat = 10;
        clear_q();
        kick(s);
        repeat (3) @(negedge clk);
        old_v = tbl[0][0];
        write_cell(0, 0, ~old_v, 1'b0);
        write_cell(1, 5, ~tbl[1][5], 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(1000, t);
        verify_frame(s, 2, 60, 10, t);
        run_frame(2, 60, 10, 1'b0, 1'b1);

        rst_mid(203);
        rst_mid(250);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
